// File: rtl/steer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : steer_pkg
//  Description : Shared definitions for the steering-enable block: FSM state
//                encodings, balance-timer expiry constants and default
//                rider-weight thresholds.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package steer_pkg;

    // FSM state encodings
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WAIT  = 2'd1;
    localparam state_t ST_STEER = 2'd2;

    // Balance timer
    localparam int             TMR_W        = 26;
    localparam logic [25:0]    TMR_EXP_FULL = 26'h3FE_56C0; // 1.34 s at 50 MHz
    localparam logic [14:0]    TMR_EXP_FAST = 15'h7FFF;     // fullchip sim

    // Rider-weight defaults
    localparam logic [11:0]    MIN_RIDER_WT_DEF = 12'h200;
    localparam logic [11:0]    WT_HYST_DEF      = 12'h040;

endpackage : steer_pkg
`default_nettype wire

// File: rtl/steer_tmr.sv
`default_nettype none
// ============================================================================
//  Module      : steer_tmr
//  Description : 26-bit balance timer with expiry compare. Clear has priority
//                over increment; the count saturates rather than wrapping and
//                holds whenever neither clr nor inc is asserted.
//  Ports       : clk      - system clock
//                rst_n    - synchronous active-low reset
//                clr      - clear timer to zero
//                inc      - advance timer by one
//                fast_sim - select short expiry (low 15 bits all ones)
//                expired  - timer currently equals the selected expiry value
//  Revision    : 1.0 - initial release
// ============================================================================
module steer_tmr
    import steer_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    input  logic fast_sim,
    output logic expired
);

    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;

    always_comb begin
        tmr_d = tmr_q;
        if (clr) begin
            tmr_d = '0;
        end else if (inc && (tmr_q != {TMR_W{1'b1}})) begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    // Fast mode only looks at the low bits so fullchip sims reach expiry quickly
    assign expired = fast_sim ? (tmr_q[14:0] == TMR_EXP_FAST)
                              : (tmr_q == TMR_EXP_FULL);

endmodule : steer_tmr
`default_nettype wire

// File: rtl/steer_en.sv
`default_nettype none
// ============================================================================
//  Module      : steer_en
//  Description : Rider detection and steering enable. Sums and differences
//                the two load cells, and runs an IDLE/WAIT/STEER FSM that
//                only enables steering after the rider has stood balanced
//                for a full timer period.
//  Ports       : clk       - system clock
//                rst_n     - synchronous active-low reset
//                lft_ld    - left load-cell reading (12-bit unsigned)
//                rght_ld   - right load-cell reading (12-bit unsigned)
//                en_steer  - registered, high while in STEER
//                rider_off - registered, high while in IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module steer_en
    import steer_pkg::*;
#(
    parameter bit          fast_sim     = 1'b0,
    parameter logic [11:0] MIN_RIDER_WT = MIN_RIDER_WT_DEF,
    parameter logic [11:0] WT_HYST      = WT_HYST_DEF
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off
);

    localparam logic [12:0] THR_LO = {1'b0, MIN_RIDER_WT};
    localparam logic [12:0] THR_HI = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYST};

    // ------------------------------------------------------------------
    // Threshold arithmetic (13-bit, no truncation)
    // ------------------------------------------------------------------
    logic        [12:0] sum;
    logic signed [12:0] diff_s;
    logic        [12:0] diff;
    logic               sum_lt_min;
    logic               sum_gt_min;
    logic               diff_small;
    logic               diff_big;

    assign sum        = {1'b0, lft_ld} + {1'b0, rght_ld};
    assign diff_s     = $signed({1'b0, lft_ld}) - $signed({1'b0, rght_ld});
    assign diff       = diff_s[12] ? $unsigned(-diff_s) : $unsigned(diff_s);
    assign sum_lt_min = (sum < THR_LO);
    assign sum_gt_min = (sum > THR_HI);
    assign diff_small = (diff < (sum >> 2));
    assign diff_big   = (diff > (sum - (sum >> 4)));

    // ------------------------------------------------------------------
    // Balance timer
    // ------------------------------------------------------------------
    logic tmr_clr;
    logic tmr_inc;
    logic tmr_expired;

    steer_tmr u_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tmr_clr),
        .inc      (tmr_inc),
        .fast_sim (fast_sim),
        .expired  (tmr_expired)
    );

    // ------------------------------------------------------------------
    // FSM: state register (outputs registered alongside the state)
    // ------------------------------------------------------------------
    state_t state_q;
    state_t state_d;
    logic   en_steer_q;
    logic   en_steer_d;
    logic   rider_off_q;
    logic   rider_off_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            en_steer_q  <= 1'b0;
            rider_off_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            en_steer_q  <= en_steer_d;
            rider_off_q <= rider_off_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        tmr_clr = 1'b0;
        tmr_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sum_gt_min) begin
                    state_d = ST_WAIT;
                    tmr_clr = 1'b1;
                end
            end
            ST_WAIT: begin
                if (sum_lt_min) begin
                    state_d = ST_IDLE;
                end else if (!diff_small) begin
                    tmr_clr = 1'b1;
                end else if (tmr_expired) begin
                    state_d = ST_STEER;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ST_STEER: begin
                if (sum_lt_min) begin
                    state_d = ST_IDLE;
                end else if (diff_big) begin
                    state_d = ST_WAIT;
                    tmr_clr = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from next state so the registered outputs
    // track the state register edge for edge
    // ------------------------------------------------------------------
    always_comb begin
        en_steer_d  = (state_d == ST_STEER);
        rider_off_d = (state_d == ST_IDLE);
    end

    assign en_steer  = en_steer_q;
    assign rider_off = rider_off_q;

endmodule : steer_en
`default_nettype wire

// File: tb/tb_steer_en.sv
`default_nettype none
// ============================================================================
//  Module      : tb_steer_en
//  Description : Self-checking bench for steer_en (fast_sim=1). A behavioural
//                reference model pushes expected outputs into a queue as each
//                stimulus cycle is driven; they are popped and compared after
//                the clock edge. Directed checks cover latencies and the
//                hysteresis band.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_steer_en;

    logic        clk;
    logic        rst_n;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        en_steer;
    logic        rider_off;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] exp_q [$];

    // reference model state: 0=idle 1=wait 2=steer
    int m_st = 0;
    int m_t  = 0;

    steer_en #(
        .fast_sim     (1'b1),
        .MIN_RIDER_WT (12'h200),
        .WT_HYST      (12'h040)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .en_steer  (en_steer),
        .rider_off (rider_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input int l, input int r, input logic rn);
        int s;
        int d;
        s = l + r;
        d = (l > r) ? (l - r) : (r - l);
        if (!rn) begin
            m_st = 0;
            m_t  = 0;
        end else begin
            case (m_st)
                0: if (s > 'h240) begin m_st = 1; m_t = 0; end
                1: begin
                    if (s < 'h200)          m_st = 0;
                    else if (!(d < s / 4))  m_t  = 0;
                    else if (m_t == 32767)  m_st = 2;
                    else                    m_t  = m_t + 1;
                end
                default: begin
                    if (s < 'h200)               m_st = 0;
                    else if (d > s - s / 16) begin m_st = 1; m_t = 0; end
                end
            endcase
        end
    endtask

    // One clock of stimulus; the scoreboard entry is compared after the edge
    task automatic step(input logic [11:0] l, input logic [11:0] r, input logic rn);
        logic [1:0] e;
        lft_ld  = l;
        rght_ld = r;
        rst_n   = rn;
        model_update(int'(l), int'(r), rn);
        exp_q.push_back({(m_st == 2), (m_st == 0)});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val("sb_en_steer",  {31'd0, en_steer},  {31'd0, e[1]});
        check_val("sb_rider_off", {31'd0, rider_off}, {31'd0, e[0]});
    endtask

    task automatic run_until_steer(input logic [11:0] l, input logic [11:0] r, output int n);
        n = 0;
        do begin
            step(l, r, 1'b1);
            n++;
        end while (en_steer !== 1'b1 && n < 40000);
    endtask

    initial begin
        int n;
        lft_ld  = '0;
        rght_ld = '0;
        rst_n   = 1'b0;

        // Reset and idle with no load
        step(12'h000, 12'h000, 1'b0);
        step(12'h000, 12'h000, 1'b0);
        check_val("rst_en_steer",  {31'd0, en_steer},  32'd0);
        check_val("rst_rider_off", {31'd0, rider_off}, 32'd1);
        repeat (5) step(12'h000, 12'h000, 1'b1);
        check_val("idle_rider_off", {31'd0, rider_off}, 32'd1);

        // Mount balanced: rider_off drops after one clk, steer after full period
        step(12'h300, 12'h300, 1'b1);
        check_val("mount_rider_off", {31'd0, rider_off}, 32'd0);
        check_val("mount_en_steer",  {31'd0, en_steer},  32'd0);
        run_until_steer(12'h300, 12'h300, n);
        check_val("mount_latency", n, 32'd32768);

        // Reset while steering
        step(12'h300, 12'h300, 1'b0);
        check_val("rst_steer_en",  {31'd0, en_steer},  32'd0);
        check_val("rst_steer_off", {31'd0, rider_off}, 32'd1);

        // Re-mount leaning for 20000 clk, then rebalance: full period needed
        step(12'h400, 12'h100, 1'b1);
        check_val("lean_rider_off", {31'd0, rider_off}, 32'd0);
        repeat (19999) step(12'h400, 12'h100, 1'b1);
        check_val("lean_en_steer", {31'd0, en_steer}, 32'd0);
        run_until_steer(12'h300, 12'h300, n);
        check_val("lean_latency", n, 32'd32768);

        // Step-off imbalance in STEER drops back to WAIT
        step(12'h7F0, 12'h010, 1'b1);
        check_val("stepoff_en_steer",  {31'd0, en_steer},  32'd0);
        check_val("stepoff_rider_off", {31'd0, rider_off}, 32'd0);
        repeat (1000) step(12'h300, 12'h300, 1'b1);
        check_val("stepoff_restart", {31'd0, en_steer}, 32'd0);

        // Sum exactly at MIN_RIDER_WT holds WAIT
        step(12'h100, 12'h100, 1'b1);
        check_val("band_lo_hold", {31'd0, rider_off}, 32'd0);

        // Dismount and hysteresis band from IDLE
        step(12'h0C0, 12'h0C0, 1'b1);
        check_val("dismount_off", {31'd0, rider_off}, 32'd1);
        step(12'h110, 12'h110, 1'b1);
        check_val("band_mid_hold", {31'd0, rider_off}, 32'd1);
        step(12'h120, 12'h120, 1'b1);
        check_val("band_hi_hold", {31'd0, rider_off}, 32'd1);
        step(12'h120, 12'h121, 1'b1);
        check_val("band_exit_wait", {31'd0, rider_off}, 32'd0);
        check_val("band_exit_en",   {31'd0, en_steer},  32'd0);

        check_val("sb_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_steer_en
`default_nettype wire
